// File: rtl/mips32_pkg.sv
// Shared mips32 definitions: data width, responder FSM states and
// the LW/SW opcodes that the MEM stage and memory responder both use.
package mips32_pkg;

    localparam int DATA_W = 32;

    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_store(input logic [5:0] op);
        return op == OP_SW;
    endfunction

endpackage

// File: rtl/mips32_mem_array.sv
// Single-port synchronous RAM, DEPTH x 32, read-first.
// Ports: clk, i_en (access strobe), i_we, i_addr, i_wdata, o_rdata (registered).
module mips32_mem_array
    import mips32_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset: contents persist across rst_n.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                mem[i_addr] <= i_wdata;
            end
            o_rdata <= mem[i_addr];
        end
    end

endmodule

// File: rtl/mips32_mem_responder.sv
// Word-addressed memory responder: one request at a time over valid/ready,
// one response after WAIT_STATES extra cycles. Ports: clk, rst_n, req_*, rsp_*.
module mips32_mem_responder
    import mips32_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    if (WAIT_STATES > 15 || WAIT_STATES < 0) begin : g_bad_wait
        $error("WAIT_STATES must be in 0..15");
    end

    localparam logic [3:0]      W_CNT   = 4'(WAIT_STATES);
    localparam bit              NO_WAIT = (WAIT_STATES == 0);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic                r_we;
    logic                r_err;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic                w_accept;
    logic                w_req_oor;
    logic                w_enter_resp;
    logic                w_use_req;
    logic                w_sel_we;
    logic                w_sel_err;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_ram_en;
    logic                w_ram_we;
    logic [DATA_W-1:0]   w_ram_rdata;

    // rst_n gates ready so nothing is accepted while reset is held.
    assign req_ready = rst_n && (r_state == ST_IDLE);
    assign w_accept  = req_valid && req_ready;
    assign w_req_oor = {1'b0, req_addr} >= DEPTH_C;

    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (NO_WAIT) begin
                        w_next = ST_RESP;
                    end else begin
                        w_next    = ST_WAIT;
                        w_cnt_nxt = 4'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == W_CNT) begin
                    w_next    = ST_RESP;
                    w_cnt_nxt = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next    = ST_IDLE;
                w_cnt_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_we    <= req_we;
                r_err   <= w_req_oor;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
        end
    end

    // The array is touched only on the edge that enters RESP. With no
    // wait states that edge is the accept edge, so the live request
    // fields feed the RAM; otherwise the latched copy does.
    assign w_enter_resp = (r_state != ST_RESP) && (w_next == ST_RESP);
    assign w_use_req    = (r_state == ST_IDLE);
    assign w_sel_we     = w_use_req ? req_we    : r_we;
    assign w_sel_err    = w_use_req ? w_req_oor : r_err;
    assign w_sel_addr   = w_use_req ? req_addr  : r_addr;
    assign w_sel_wdata  = w_use_req ? req_wdata : r_wdata;
    assign w_ram_en     = w_enter_resp && !w_sel_err;
    assign w_ram_we     = w_ram_en && w_sel_we;

    mips32_mem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_sel_addr),
        .i_wdata (w_sel_wdata),
        .o_rdata (w_ram_rdata)
    );

    // The RAM output register is not reset, so data is masked outside RESP.
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_err   = rsp_valid && r_err;
    assign rsp_rdata = (rsp_valid && !r_we && !r_err) ? w_ram_rdata : '0;

endmodule

// File: tb/tb_mips32_mem_responder.sv
// Self-checking bench: dut0 (DEPTH 1024, no wait states) and
// dut1 (DEPTH 1000, 3 wait states) against a flat word-array model.
module tb_mips32_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [9:0]  req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_rdata [2];
    logic [1:0]  rsp_err;

    logic [31:0] model [2][1024];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips32_mem_responder #(
        .DEPTH(1024), .ADDR_W(10), .WAIT_STATES(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    mips32_mem_responder #(
        .DEPTH(1000), .ADDR_W(10), .WAIT_STATES(3)
    ) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    function automatic int wst(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic int depth(input int d);
        return (d == 0) ? 1024 : 1000;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One full transaction with optional response backpressure.
    task automatic txn(input int d, input bit we, input logic [9:0] addr,
                       input logic [31:0] wdata, input int stall,
                       input logic [31:0] exp_rdata, input bit exp_err,
                       input string nm);
        int n;
        int lat;
        bit busy_ok;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        rsp_ready[d] = 1'b0;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            errors++;
            $display("FAIL %s_accept: req_ready never rose", nm);
        end
        @(negedge clk);
        req_valid[d] = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!rsp_valid[d] && lat < 30) begin
            if (req_ready[d]) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        check({nm, "_lat"}, 32'(lat), 32'(1 + wst(d)));
        check({nm, "_busy"}, {31'd0, busy_ok}, 32'd1);
        check({nm, "_rdata"}, rsp_rdata[d], exp_rdata);
        check({nm, "_err"}, {31'd0, rsp_err[d]}, {31'd0, exp_err});
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check({nm, "_hold_v"}, {31'd0, rsp_valid[d]}, 32'd1);
            check({nm, "_hold_d"}, rsp_rdata[d], exp_rdata);
        end
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        check({nm, "_done"}, {31'd0, rsp_valid[d]}, 32'd0);
    endtask

    // Transaction whose expectation comes from the word-array model.
    task automatic model_txn(input int d, input bit we,
                             input logic [9:0] addr,
                             input logic [31:0] wdata, input int stall,
                             input string nm);
        bit oor;
        logic [31:0] exp;
        oor = int'(addr) >= depth(d);
        exp = (we || oor) ? 32'd0 : model[d][addr];
        txn(d, we, addr, wdata, stall, exp, oor, nm);
        if (we && !oor) model[d][addr] = wdata;
    endtask

    typedef struct {
        int          d;
        bit          we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        int          stall;
        logic [31:0] exp_rdata;
        bit          exp_err;
        string       nm;
    } vec_t;

    vec_t tbl [7];

    initial begin
        logic [31:0] v;
        bit flag;
        rst_n     = 1'b0;
        req_valid = '0;
        req_we    = '0;
        rsp_ready = '0;
        for (int i = 0; i < 2; i++) begin
            req_addr[i]  = '0;
            req_wdata[i] = '0;
        end
        for (int k = 0; k < 1024; k++) begin
            v = $urandom;
            model[0][k] = v;
            dut0.u_array.mem[k] = v;
        end
        for (int k = 0; k < 1000; k++) begin
            v = $urandom;
            model[1][k] = v;
            dut1.u_array.mem[k] = v;
        end
        model[1][198] = 32'hDEADBEEF;
        dut1.u_array.mem[198] = 32'hDEADBEEF;
        model[1][999] = 32'h0999_0999;
        dut1.u_array.mem[999] = 32'h0999_0999;
        model[0][300] = 32'h3003_0300;
        dut0.u_array.mem[300] = 32'h3003_0300;
        model[0][301] = 32'h3013_0301;
        dut0.u_array.mem[301] = 32'h3013_0301;

        repeat (2) @(negedge clk);
        check("rst_rdy0", {30'd0, req_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_rdy1", {30'd0, req_ready}, 32'd3);
        check("rst_vld", {30'd0, rsp_valid}, 32'd0);
        check("rst_err", {30'd0, rsp_err}, 32'd0);

        tbl[0] = '{0, 1'b1, 10'd200, 32'h0000000A, 0, 32'h0, 1'b0, "w0_wr200"};
        tbl[1] = '{0, 1'b0, 10'd200, 32'h0, 0, 32'h0000000A, 1'b0, "w0_rd200"};
        tbl[2] = '{1, 1'b0, 10'd198, 32'h0, 0, 32'hDEADBEEF, 1'b0, "w3_rd198"};
        tbl[3] = '{1, 1'b1, 10'd1000, 32'h1, 0, 32'h0, 1'b1, "oor_wr1000"};
        tbl[4] = '{1, 1'b0, 10'd999, 32'h0, 0, 32'h0999_0999, 1'b0, "oor_rd999"};
        tbl[5] = '{1, 1'b0, 10'd1023, 32'h0, 1, 32'h0, 1'b1, "oor_rd1023"};
        tbl[6] = '{0, 1'b0, 10'd1023, 32'h0, 2, 32'h0, 1'b0, "w0_rd1023"};
        tbl[6].exp_rdata = model[0][1023];
        foreach (tbl[i]) begin
            txn(tbl[i].d, tbl[i].we, tbl[i].addr, tbl[i].wdata,
                tbl[i].stall, tbl[i].exp_rdata, tbl[i].exp_err,
                tbl[i].nm);
            if (tbl[i].we && !tbl[i].exp_err)
                model[tbl[i].d][tbl[i].addr] = tbl[i].wdata;
        end

        // Backpressure with a second request waiting behind it.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 10'd300;
        check("bp_rdy_idle", {31'd0, req_ready[0]}, 32'd1);
        @(negedge clk);
        req_addr[0] = 10'd301;
        for (int s = 0; s < 5; s++) begin
            check("bp_vld", {31'd0, rsp_valid[0]}, 32'd1);
            check("bp_data", rsp_rdata[0], 32'h3003_0300);
            check("bp_rdy_busy", {31'd0, req_ready[0]}, 32'd0);
            @(negedge clk);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        check("bp_rdy_back", {31'd0, req_ready[0]}, 32'd1);
        check("bp_vld_low", {31'd0, rsp_valid[0]}, 32'd0);
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("bp_2nd_vld", {31'd0, rsp_valid[0]}, 32'd1);
        check("bp_2nd_data", rsp_rdata[0], 32'h3013_0301);
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        rsp_ready[0] = 1'b0;

        // Reset while dut0 holds a committed write response (RESP)
        // and dut1 is in the middle of WAIT with a write pending.
        @(negedge clk);
        req_valid = 2'b11;
        req_we    = 2'b11;
        req_addr[0]  = 10'd400;
        req_wdata[0] = 32'h44;
        req_addr[1]  = 10'd5;
        req_wdata[1] = 32'h55;
        @(negedge clk);
        req_valid = 2'b00;
        check("rr_resp_vld", {31'd0, rsp_valid[0]}, 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_rdy", {30'd0, req_ready}, 32'd0);
        check("ar_vld", {30'd0, rsp_valid}, 32'd0);
        check("ar_err", {30'd0, rsp_err}, 32'd0);
        check("ar_rdata0", rsp_rdata[0], 32'd0);
        check("ar_rdata1", rsp_rdata[1], 32'd0);
        model[0][400] = 32'h44;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ar_rdy_rel", {30'd0, req_ready}, 32'd3);
        flag = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) flag = 1'b1;
        end
        check("ar_no_rsp", {31'd0, flag}, 32'd0);
        model_txn(1, 1'b0, 10'd5, 32'h0, 0, "ar_rd5");
        model_txn(0, 1'b0, 10'd400, 32'h0, 0, "ar_rd400");

        // Random traffic against the model.
        for (int i = 0; i < 60; i++) begin
            int d;
            logic [9:0] a;
            d = i % 2;
            a = 10'($urandom_range(1023, 0));
            if ($urandom_range(7, 0) == 0 && d == 1)
                a = 10'($urandom_range(1023, 1000));
            else if ($urandom_range(3, 0) == 0)
                a = 10'($urandom_range(15, 0));
            model_txn(d, 1'($urandom), a, $urandom,
                      int'($urandom_range(2, 0)), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
